hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/hazard_unit_if.sv | 33 +++
 rtl/perf_counter.sv | 19 +
 rtl/hazard_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the latch-enable/flush bundle used by the hazard unit.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } hazstate_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } hazctl_t;

  localparam hazctl_t CTL_RUN    = hazctl_t'(8'b1111_1000);
  localparam hazctl_t CTL_FROZEN = hazctl_t'(8'b0000_0000);

  // Branch flush wins over the load-use bubble, which wins over an icache miss.
  function automatic hazctl_t run_rules(input logic ihit, input logic load_use,
                                        input logic pcsrc);
    hazctl_t c;
    c = CTL_RUN;
    if (pcsrc) begin
      c.ifid_flush  = 1'b1;
      c.idex_flush  = 1'b1;
      c.exmem_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end else if (!ihit) begin
      c.pc_en      = 1'b0;
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
interface hazard_unit_if #(parameter int CNT_W = 32);
  import cpu_types_pkg::*;

  regbits_t         ifid_rs;
  regbits_t         ifid_rt;
  logic             idex_MemRd;
  regbits_t         idex_wsel;
  logic             exmem_pcsrc;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             dhit;
  logic             ihit;
  logic             exmem_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  hazstate_t        state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport hu (
    input  ifid_rs, ifid_rt, idex_MemRd, idex_wsel, exmem_pcsrc,
           exmem_dREN, exmem_dWEN, dhit, ihit, exmem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter, wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, dcache waits, halt.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input logic        CLK,
  input logic        nRST,
  hazard_unit_if.hu  hu
);
  import cpu_types_pkg::*;

  hazstate_t state_q;
  hazstate_t state_d;
  hazctl_t   ctl;
  logic      load_use;
  logic      mem_req;
  logic      stall_inc;

  assign load_use = hu.idex_MemRd && (hu.idex_wsel != '0) &&
                    ((hu.idex_wsel == hu.ifid_rs) || (hu.idex_wsel == hu.ifid_rt));
  assign mem_req  = hu.exmem_dREN || hu.exmem_dWEN;

  always_comb begin
    ctl     = CTL_RUN;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_req && !hu.dhit) begin
          ctl     = CTL_FROZEN;
          state_d = MEMWAIT;
        end else begin
          ctl = run_rules(hu.ihit, load_use, hu.exmem_pcsrc);
          if (hu.exmem_halt) state_d = HALTED;
        end
      end
      MEMWAIT: begin
        if (!hu.dhit) begin
          ctl = CTL_FROZEN;
        end else begin
          // Data returns: retire MEM into WB and bubble EX/MEM behind it.
          ctl             = run_rules(hu.ihit, load_use, hu.exmem_pcsrc);
          ctl.memwb_en    = 1'b1;
          ctl.exmem_flush = 1'b1;
          state_d         = hu.exmem_halt ? HALTED : RUN;
        end
      end
      HALTED: ctl = CTL_FROZEN;
      default: begin
        ctl     = CTL_FROZEN;
        state_d = RUN;
      end
    endcase
    // Held in reset the pipeline free-runs with no bubbles.
    if (!nRST) ctl = CTL_RUN;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign stall_inc = !ctl.pc_en && (state_q != HALTED);

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (hu.stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (ctl.idex_flush),
    .count (hu.flush_cnt)
  );

  assign hu.pc_en       = ctl.pc_en;
  assign hu.ifid_en     = ctl.ifid_en;
  assign hu.idex_en     = ctl.idex_en;
  assign hu.exmem_en    = ctl.exmem_en;
  assign hu.memwb_en    = ctl.memwb_en;
  assign hu.ifid_flush  = ctl.ifid_flush;
  assign hu.idex_flush  = ctl.idex_flush;
  assign hu.exmem_flush = ctl.exmem_flush;
  assign hu.state       = state_q;

endmodule
